// File: rtl/param_entry_if.sv
// Key inputs and parameter-word outputs of the parameter entry block.
interface param_entry_if;
    logic       key_sel;
    logic       key_up;
    logic       key_down;
    logic [5:0] Fword1;
    logic [7:0] Fword2;
    logic [8:0] Pword2;
    logic [1:0] field_sel;
    logic       upd_pulse;

    // Driver side: presses the keys and watches the words.
    modport master (
        output key_sel,
        output key_up,
        output key_down,
        input  Fword1,
        input  Fword2,
        input  Pword2,
        input  field_sel,
        input  upd_pulse
    );

    // Block side: reads the raw keys and owns the words.
    modport slave (
        input  key_sel,
        input  key_up,
        input  key_down,
        output Fword1,
        output Fword2,
        output Pword2,
        output field_sel,
        output upd_pulse
    );
endinterface

// File: rtl/param_entry.sv
// Three-button parameter entry: debounced select/up/down keys with auto-repeat
// edit three wrapped words (Fword1 0..63, Fword2 0..255, Pword2 0..359).
module param_entry #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned REP_DELAY  = 64,
    parameter int unsigned REP_PERIOD = 8
) (
    input logic          sys_clk,
    input logic          sys_rst,
    param_entry_if.slave bus
);

    localparam int unsigned DebW   = $clog2(DEB_CYCLES + 1);
    localparam int unsigned RepMax = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned RepW   = $clog2(RepMax + 1);

    localparam logic [DebW-1:0] DebLast   = DebW'(DEB_CYCLES - 1);
    localparam logic [RepW-1:0] RepDelayC = RepW'(REP_DELAY);
    localparam logic [RepW-1:0] RepPerC   = RepW'(REP_PERIOD);

    // Key index: 0 = select, 1 = up, 2 = down.
    localparam int KSel  = 0;
    localparam int KUp   = 1;
    localparam int KDown = 2;

    typedef enum logic [1:0] {StF1 = 2'd0, StF2 = 2'd1, StP2 = 2'd2} field_e;

    logic [2:0]      raw_keys;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      deb_q, deb_d;
    logic [2:0]      press_q, press_d;
    logic [DebW-1:0] deb_cnt_q [3];
    logic [DebW-1:0] deb_cnt_d [3];

    // Repeat engines: index 0 = up, 1 = down.
    logic [RepW-1:0] rep_cnt_q [2];
    logic [RepW-1:0] rep_cnt_d [2];
    logic [1:0]      rep_run_q, rep_run_d;
    logic [1:0]      rep_step;
    logic            both_held;

    logic            up_step, down_step, inc, dec;

    field_e          state_q, state_d;
    logic [1:0]      field_sel;

    logic [5:0]      fw1_q, fw1_d;
    logic [7:0]      fw2_q, fw2_d;
    logic [8:0]      pw2_q, pw2_d;
    logic            upd_q;

    assign raw_keys = {bus.key_down, bus.key_up, bus.key_sel};

    // Two-flop synchronizers for the asynchronous raw keys.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_keys;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count cycles of disagreement, flip once the window is filled.
    always_comb begin
        deb_d   = deb_q;
        press_d = '0;
        for (int k = 0; k < 3; k++) begin
            deb_cnt_d[k] = deb_cnt_q[k];
            if (sync2_q[k] == deb_q[k]) begin
                deb_cnt_d[k] = '0;
            end else if (deb_cnt_q[k] == DebLast) begin
                deb_cnt_d[k] = '0;
                deb_d[k]     = ~deb_q[k];
                press_d[k]   = ~deb_q[k];
            end else begin
                deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
            end
        end
    end

    // Debounced state, press pulses and debounce counters.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            deb_q   <= '0;
            press_q <= '0;
            for (int k = 0; k < 3; k++) begin
                deb_cnt_q[k] <= '0;
            end
        end else begin
            deb_q   <= deb_d;
            press_q <= press_d;
            for (int k = 0; k < 3; k++) begin
                deb_cnt_q[k] <= deb_cnt_d[k];
            end
        end
    end

    assign both_held = deb_q[KUp] & deb_q[KDown];

    // Auto-repeat: counter holds cycles since press; delay phase then period phase.
    // Both keys held freezes both engines; a select press restarts a held key.
    always_comb begin
        rep_run_d = rep_run_q;
        rep_step  = '0;
        for (int r = 0; r < 2; r++) begin
            rep_cnt_d[r] = rep_cnt_q[r];
            if (!deb_q[r+1]) begin
                rep_cnt_d[r] = '0;
                rep_run_d[r] = 1'b0;
            end else if (press_q[r+1] || press_q[KSel]) begin
                rep_cnt_d[r] = RepW'(1);
                rep_run_d[r] = 1'b0;
            end else if (!both_held) begin
                if (!rep_run_q[r] && rep_cnt_q[r] == RepDelayC) begin
                    rep_step[r]  = 1'b1;
                    rep_run_d[r] = 1'b1;
                    rep_cnt_d[r] = RepW'(1);
                end else if (rep_run_q[r] && rep_cnt_q[r] == RepPerC) begin
                    rep_step[r]  = 1'b1;
                    rep_cnt_d[r] = RepW'(1);
                end else begin
                    rep_cnt_d[r] = rep_cnt_q[r] + 1'b1;
                end
            end
        end
    end

    // Repeat counters and phase flags.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rep_run_q <= '0;
            for (int r = 0; r < 2; r++) begin
                rep_cnt_q[r] <= '0;
            end
        end else begin
            rep_run_q <= rep_run_d;
            for (int r = 0; r < 2; r++) begin
                rep_cnt_q[r] <= rep_cnt_d[r];
            end
        end
    end

    // Simultaneous up and down steps cancel.
    assign up_step   = press_q[KUp] | rep_step[0];
    assign down_step = press_q[KDown] | rep_step[1];
    assign inc       = up_step & ~down_step;
    assign dec       = down_step & ~up_step;

    // Field FSM: state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StF1;
        end else begin
            state_q <= state_d;
        end
    end

    // Field FSM: select press advances F1 -> F2 -> P2 -> F1.
    always_comb begin
        state_d = state_q;
        if (press_q[KSel]) begin
            unique case (state_q)
                StF1:    state_d = StF2;
                StF2:    state_d = StP2;
                StP2:    state_d = StF1;
                default: state_d = StF1;
            endcase
        end
    end

    // Field FSM: output decode.
    always_comb begin
        field_sel = 2'd0;
        unique case (state_q)
            StF1:    field_sel = 2'd0;
            StF2:    field_sel = 2'd1;
            StP2:    field_sel = 2'd2;
            default: field_sel = 2'd0;
        endcase
    end

    // Word next-state: step applies to the field selected before any advance.
    always_comb begin
        fw1_d = fw1_q;
        fw2_d = fw2_q;
        pw2_d = pw2_q;
        if (inc || dec) begin
            unique case (state_q)
                StF1: fw1_d = inc ? fw1_q + 6'd1 : fw1_q - 6'd1;
                StF2: fw2_d = inc ? fw2_q + 8'd1 : fw2_q - 8'd1;
                StP2: begin
                    if (inc) begin
                        pw2_d = (pw2_q == 9'd359) ? 9'd0 : pw2_q + 9'd1;
                    end else begin
                        pw2_d = (pw2_q == 9'd0) ? 9'd359 : pw2_q - 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Word registers; every non-cancelled step changes a word, so it also strobes.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fw1_q <= '0;
            fw2_q <= '0;
            pw2_q <= '0;
            upd_q <= 1'b0;
        end else begin
            fw1_q <= fw1_d;
            fw2_q <= fw2_d;
            pw2_q <= pw2_d;
            upd_q <= inc | dec;
        end
    end

    assign bus.Fword1    = fw1_q;
    assign bus.Fword2    = fw2_q;
    assign bus.Pword2    = pw2_q;
    assign bus.field_sel = field_sel;
    assign bus.upd_pulse = upd_q;

endmodule

// File: tb/tb_param_entry.sv
// Directed bench for param_entry with a short debounce and repeat timing.
module tb_param_entry;

    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 20;
    localparam int unsigned RP  = 8;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;
    int lat;

    param_entry_if bus ();

    param_entry #(
        .DEB_CYCLES (DEB),
        .REP_DELAY  (RD),
        .REP_PERIOD (RP)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock, then sample 1 ns after the edge and tally strobes.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (bus.upd_pulse === 1'b1) upd_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Clean press held long enough to debounce but well short of auto-repeat.
    task automatic press_key(input int k);
        if (k == 0) bus.key_sel = 1'b1;
        if (k == 1) bus.key_up = 1'b1;
        if (k == 2) bus.key_down = 1'b1;
        run(10);
        bus.key_sel  = 1'b0;
        bus.key_up   = 1'b0;
        bus.key_down = 1'b0;
        run(14);
    endtask

    task automatic apply_reset();
        sys_rst = 1'b1;
        run(2);
        sys_rst = 1'b0;
    endtask

    initial begin
        bus.key_sel  = 1'b0;
        bus.key_up   = 1'b0;
        bus.key_down = 1'b0;
        run(3);
        check_eq("rst_fword1", 32'(bus.Fword1), 0);
        check_eq("rst_fword2", 32'(bus.Fword2), 0);
        check_eq("rst_pword2", 32'(bus.Pword2), 0);
        check_eq("rst_field", 32'(bus.field_sel), 0);
        check_eq("rst_upd", 32'(bus.upd_pulse), 0);
        sys_rst = 1'b0;

        // Clean up press in F1: word changes on the 7th edge after the raw edge.
        bus.key_up = 1'b1;
        run(6);
        check_eq("lat_before", 32'(bus.Fword1), 0);
        check_eq("lat_upd_before", 32'(bus.upd_pulse), 0);
        tick();
        check_eq("lat_fword1", 32'(bus.Fword1), 1);
        check_eq("lat_upd", 32'(bus.upd_pulse), 1);
        tick();
        check_eq("upd_one_cycle", 32'(bus.upd_pulse), 0);
        bus.key_up = 1'b0;
        run(14);
        check_eq("single_step", 32'(bus.Fword1), 1);

        // Select and up together: step lands on F1, field moves to F2.
        bus.key_sel = 1'b1;
        bus.key_up  = 1'b1;
        run(10);
        bus.key_sel = 1'b0;
        bus.key_up  = 1'b0;
        run(14);
        check_eq("coinc_fword1", 32'(bus.Fword1), 2);
        check_eq("coinc_fword2", 32'(bus.Fword2), 0);
        check_eq("coinc_field", 32'(bus.field_sel), 1);

        // Wrap boundaries on all three words.
        apply_reset();
        press_key(2);
        check_eq("f1_wrap_down", 32'(bus.Fword1), 63);
        press_key(0);
        check_eq("field_f2", 32'(bus.field_sel), 1);
        press_key(0);
        check_eq("field_p2", 32'(bus.field_sel), 2);
        press_key(2);
        check_eq("p2_wrap_down", 32'(bus.Pword2), 359);
        press_key(1);
        check_eq("p2_wrap_up", 32'(bus.Pword2), 0);
        check_eq("f1_hold", 32'(bus.Fword1), 63);
        press_key(0);
        check_eq("field_f1", 32'(bus.field_sel), 0);
        press_key(0);
        press_key(2);
        check_eq("f2_wrap_down", 32'(bus.Fword2), 255);
        press_key(1);
        check_eq("f2_wrap_up", 32'(bus.Fword2), 0);

        // Three-cycle glitch is filtered out.
        upd_cnt = 0;
        bus.key_up = 1'b1;
        run(3);
        bus.key_up = 1'b0;
        run(15);
        check_eq("glitch_upd", 32'(upd_cnt), 0);
        check_eq("glitch_fword2", 32'(bus.Fword2), 0);

        // Auto-repeat in F2: press step, first repeat, three periodic repeats.
        upd_cnt = 0;
        lat = 0;
        bus.key_up = 1'b1;
        while (upd_cnt == 0 && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("rep_press_lat", 32'(lat), 7);
        run(RD + 3 * RP);
        check_eq("rep_last_upd", 32'(bus.upd_pulse), 1);
        bus.key_up = 1'b0;
        run(14);
        check_eq("rep_count", 32'(upd_cnt), 5);
        check_eq("rep_fword2", 32'(bus.Fword2), 5);

        // Up and down together cancel and suspend repeat.
        upd_cnt = 0;
        bus.key_up   = 1'b1;
        bus.key_down = 1'b1;
        run(RD + 2 * RP);
        bus.key_up   = 1'b0;
        bus.key_down = 1'b0;
        run(14);
        check_eq("both_upd", 32'(upd_cnt), 0);
        check_eq("both_fword2", 32'(bus.Fword2), 5);
        check_eq("both_fword1", 32'(bus.Fword1), 63);
        check_eq("both_pword2", 32'(bus.Pword2), 0);

        // Bring Fword1 to 5, then reset mid-debounce with up held.
        press_key(0);
        press_key(0);
        check_eq("back_to_f1", 32'(bus.field_sel), 0);
        for (int i = 0; i < 6; i++) press_key(1);
        check_eq("f1_at_5", 32'(bus.Fword1), 5);
        bus.key_up = 1'b1;
        run(3);
        #2;
        sys_rst = 1'b1;
        #1;
        check_eq("async_rst_fword1", 32'(bus.Fword1), 0);
        check_eq("async_rst_fword2", 32'(bus.Fword2), 0);
        check_eq("async_rst_field", 32'(bus.field_sel), 0);
        run(2);
        sys_rst = 1'b0;
        run(6);
        check_eq("post_rst_before", 32'(bus.Fword1), 0);
        tick();
        check_eq("post_rst_fword1", 32'(bus.Fword1), 1);
        bus.key_up = 1'b0;
        run(14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
